// File: rtl/mandelbrot_coord_feeder_if.sv
// rtl/mandelbrot_coord_feeder_if.sv - valid/ready stream bundle for descriptors and pixel jobs
interface mandelbrot_coord_feeder_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mandelbrot_coord_feeder.sv
// rtl/mandelbrot_coord_feeder.sv - expands a line descriptor into per-pixel jobs with completion credit tracking
module mandelbrot_coord_feeder #(
    parameter int PIX_BYTES       = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    mandelbrot_coord_feeder_if.slave        in_vector_snk,
    mandelbrot_coord_feeder_if.master       out_coord_src,
    input  logic                            pix_done,
    output logic                            busy,
    output logic                            done_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [7:0]  MAX_OUT   = 8'(MAX_OUTSTANDING);
    localparam logic [31:0] ADDR_STEP = 32'(PIX_BYTES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] iters_q, iters_d;
    logic [31:0] cr_q, cr_d;
    logic [31:0] ci_q, ci_d;
    logic [31:0] step_q, step_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [7:0]  outstanding_q, outstanding_d;
    logic        underflow_q, underflow_d;

    logic snk_ready;
    logic src_valid;
    logic accept;
    logic out_fire;
    logic last_pix;

    assign accept   = in_vector_snk.valid && snk_ready;
    assign out_fire = src_valid && out_coord_src.ready;
    assign last_pix = (remaining_q == 9'd1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN exits on the same cycle the final completion is counted
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_fire && last_pix) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_d == 8'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on state (and credit for valid), never on the upstream valid
    always_comb begin
        snk_ready = 1'b0;
        src_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                snk_ready = 1'b1;
                busy      = 1'b0;
            end
            EMIT: begin
                src_valid = (outstanding_q < MAX_OUT);
            end
            DRAIN: begin
                src_valid = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign in_vector_snk.ready = snk_ready;
    assign out_coord_src.valid = src_valid;
    assign out_coord_src.data  = {addr_q, iters_q, cr_q, ci_q};
    assign done_underflow      = underflow_q;

    // Credit counter: a completion arriving alongside an issue cancels out
    always_comb begin
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;
        case ({out_fire, pix_done})
            2'b10: outstanding_d = outstanding_q + 8'd1;
            2'b01: begin
                if (outstanding_q == 8'd0) begin
                    underflow_d = 1'b1;
                end else begin
                    outstanding_d = outstanding_q - 8'd1;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Job datapath: coordinates and address accumulate per handshake
    always_comb begin
        addr_d      = addr_q;
        iters_d     = iters_q;
        cr_d        = cr_q;
        ci_d        = ci_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        if (accept) begin
            addr_d      = in_vector_snk.data[151:120];
            remaining_d = (in_vector_snk.data[119:112] == 8'd0) ? 9'd256
                                                                : {1'b0, in_vector_snk.data[119:112]};
            step_d      = in_vector_snk.data[111:80];
            iters_d     = in_vector_snk.data[79:64];
            cr_d        = in_vector_snk.data[63:32];
            ci_d        = in_vector_snk.data[31:0];
        end else if (out_fire) begin
            addr_d      = addr_q + ADDR_STEP;
            cr_d        = cr_q + step_q;
            remaining_d = remaining_q - 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q        <= '0;
            iters_q       <= '0;
            cr_q          <= '0;
            ci_q          <= '0;
            step_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            iters_q       <= iters_d;
            cr_q          <= cr_d;
            ci_q          <= ci_d;
            step_q        <= step_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

endmodule
